dec_byte_entry: RTL and testbench
=================================

// Module: dec_byte_entry
// PURPOSE
//  Button-driven decimal byte entry: user edits a 3-digit decimal value (hundreds/tens/ones)
//  with inc/dec/next buttons, then presses send to hand the binary byte to the UART transmitter.
//  Inverse of the byte-to-decimal display path. Digit outputs feed the 7-seg multiplexer;
//  tx_data/tx_start feed the UART TX start handshake.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles before a button level change is accepted
//  REPEAT_CYCLES    5000000  hold time per auto-repeat event (used only with DEC_ENTRY_AUTO_REPEAT_EN)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  reset, asynchronous, active-high
//  btn_inc    in   1  raw button, async to clk, active-high: increment digit at cursor
//  btn_dec    in   1  raw button: decrement digit at cursor
//  btn_next   in   1  raw button: advance cursor
//  btn_send   in   1  raw button: request transmit of current value
//  tx_busy    in   1  UART TX busy (high while a frame is in flight)
//  tx_data    out  8  byte to transmit; stable from tx_start until FSM returns to IDLE
//  tx_start   out  1  one-cycle start pulse to UART TX
//  hundreds   out  4  hundreds digit, 0..2
//  tens       out  4  tens digit, 0..9
//  ones       out  4  ones digit, 0..9
//  cursor     out  2  edited digit: 0=ones, 1=tens, 2=hundreds
//  value_ok   out  1  high when hundreds*100+tens*10+ones <= 255
// BEHAVIOUR
//  - Reset (async, rst=1): all digits 0, cursor 0, tx_data 0, tx_start 0, FSM IDLE,
//    synchronizers/debounced levels/counters 0; value_ok=1. No events generated on release.
//  - Input path per button: 2-FF synchronizer -> debouncer. Counter restarts on any mismatch
//    between synced level and debounced level; debounced level flips after DEBOUNCE_CYCLES
//    consecutive mismatching cycles. Press event = 1-cycle pulse on debounced rising edge.
//  - Edit (event in cycle N, digit/cursor updated at N+1):
//    inc: ones/tens 9->0 wrap, else +1; hundreds 2->0 wrap. dec: ones/tens 0->9; hundreds 0->2.
//    next: cursor 0->1->2->0. Digits independent; no carry/borrow between digits.
//  - Same-cycle events: send > next > inc/dec; inc and dec together -> both dropped.
//    Lower-priority events in the same cycle are discarded, not queued.
//  - value_ok combinational from digits; tx byte = hundreds*100+tens*10+ones, 9-bit intermediate,
//    truncated to 8 bits only when value_ok=1.
//  - TX FSM: IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//    IDLE: send event with value_ok=1 and tx_busy=0 latches tx_data, goes START.
//      send with value_ok=0 or tx_busy=1: ignored, stays IDLE.
//    START: tx_start=1 for exactly this cycle (cycle after send event); -> WAIT_BUSY.
//    WAIT_BUSY: tx_busy=1 -> WAIT_DONE. WAIT_DONE: tx_busy=0 -> IDLE.
//    Send events outside IDLE are ignored. Edits allowed in all states; tx_data unaffected.
//  - rst mid-transfer: FSM to IDLE immediately, tx_start deasserts asynchronously.
// CONFIGURATION
//  DEC_ENTRY_AUTO_REPEAT_EN defined: while inc or dec debounced level stays high (and the other
//    low), an additional event of that button fires every REPEAT_CYCLES cycles after the press
//    event; counter clears on release. Repeat events obey the same priority rules.
//  Not defined: one event per press only; repeat counter and REPEAT_CYCLES logic absent.
// TESTING (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
//  1 Reset then bounce btn_inc 1/0 every 2 cycles for 20 cycles, settle high -> ones=1 only, once.
//  2 Cursor=1, 3 inc presses, next, 2 inc, next wraps cursor to 0 -> tens=3, hundreds=2,
//    cursor=0; dec at ones=0 -> ones=9; value 239, value_ok=1.
//  3 Digits 2/5/5, send, tx_busy=0 -> tx_start pulse 1 cycle, tx_data=0xFF; raise tx_busy
//    3 cycles later, drop 10 later -> IDLE; second send during WAIT_DONE ignored.
//  4 Digits 2/6/0 (260), send -> value_ok=0, no tx_start; send with tx_busy=1 -> no tx_start.
//  5 btn_inc and btn_dec settle high same cycle -> no digit change; send+next same cycle ->
//    tx_start issued, cursor unchanged. Assert rst during WAIT_BUSY -> all outputs reset values.
//  6 With DEC_ENTRY_AUTO_REPEAT_EN, hold btn_inc 70 cycles past debounce from ones=0 ->
//    ones=4 (1 press + 3 repeats); without macro -> ones=1.

Source files
------------

// File: rtl/dec_byte_entry.sv
// dec_byte_entry: button-driven 3-digit decimal byte entry with UART TX hand-off.
// Each raw button is synchronised and debounced.
// The debounced rising edges edit the hundreds/tens/ones digits and move the cursor.
// A send press hands the binary value to the UART transmitter through a small start/busy FSM.
// Optional feature macro: DEC_ENTRY_AUTO_REPEAT_EN (auto-repeat for held inc/dec buttons).
module dec_byte_entry #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_next,
  input  logic       btn_send,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] cursor,
  output logic       value_ok
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("dec_byte_entry: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Button index map: 0=inc, 1=dec, 2=next, 3=send
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  logic [3:0]    btn_raw;
  logic [3:0]    sync0_q, sync0_d, sync1_q, sync1_d;
  logic [3:0]    lvl_q, lvl_d, evt_q, evt_d;
  logic [DW-1:0] cnt_q [4];
  logic [DW-1:0] cnt_d [4];

  logic [3:0] ones_q, ones_d, tens_q, tens_d, hundreds_q, hundreds_d;
  logic [1:0] cursor_q, cursor_d;
  logic [7:0] tx_data_q, tx_data_d;
  tx_state_t  state_q, state_d;

  logic       rep_inc_ev, rep_dec_ev;
  logic       inc_any, dec_any;
  logic       send_ev, next_ev, inc_ev, dec_ev;
  logic [8:0] value_sum;
  logic [7:0] tx_byte;

  function automatic logic [3:0] wrap_up(input logic [3:0] d, input logic [3:0] top);
    return (d >= top) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] wrap_down(input logic [3:0] d, input logic [3:0] top);
    return (d == 4'd0 || d > top) ? top : d - 4'd1;
  endfunction

  assign btn_raw = {btn_send, btn_next, btn_dec, btn_inc};

  // Two-stage synchroniser then per-button debounce; a press event is emitted on the cycle the level rises
  always_comb begin
    sync0_d = btn_raw;
    sync1_d = sync0_q;
    lvl_d   = lvl_q;
    evt_d   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync1_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          lvl_d[i] = sync1_q[i];
          evt_d[i] = sync1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Input-path registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q <= '0;
      sync1_q <= '0;
      lvl_q   <= '0;
      evt_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      lvl_q   <= lvl_d;
      evt_q   <= evt_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef DEC_ENTRY_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_inc_q, rep_inc_d, rep_dec_q, rep_dec_d;
  logic          hold_inc, hold_dec;

  assign hold_inc = lvl_q[0] & ~lvl_q[1];
  assign hold_dec = lvl_q[1] & ~lvl_q[0];

  // Count hold time while exactly one of inc/dec is held; fire a repeat every REPEAT_CYCLES
  always_comb begin
    rep_cnt_d = '0;
    rep_inc_d = 1'b0;
    rep_dec_d = 1'b0;
    if (hold_inc || hold_dec) begin
      if (rep_cnt_q == RP_LAST) begin
        rep_inc_d = hold_inc;
        rep_dec_d = hold_dec;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  // Auto-repeat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_inc_q <= 1'b0;
      rep_dec_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_inc_q <= rep_inc_d;
      rep_dec_q <= rep_dec_d;
    end
  end

  assign rep_inc_ev = rep_inc_q;
  assign rep_dec_ev = rep_dec_q;
`else
  assign rep_inc_ev = 1'b0;
  assign rep_dec_ev = 1'b0;
`endif

  // Same-cycle arbitration: send beats next beats inc/dec; inc with dec cancels both
  always_comb begin
    inc_any = evt_q[0] | rep_inc_ev;
    dec_any = evt_q[1] | rep_dec_ev;
    send_ev = evt_q[3];
    next_ev = evt_q[2] & ~send_ev;
    inc_ev  = inc_any & ~dec_any & ~send_ev & ~evt_q[2];
    dec_ev  = dec_any & ~inc_any & ~send_ev & ~evt_q[2];
  end

  // Digit and cursor editing; digits wrap independently with no carry or borrow
  always_comb begin
    ones_d     = ones_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    cursor_d   = cursor_q;
    if (next_ev) begin
      cursor_d = (cursor_q >= 2'd2) ? 2'd0 : cursor_q + 2'd1;
    end else if (inc_ev || dec_ev) begin
      case (cursor_q)
        2'd0:    ones_d     = inc_ev ? wrap_up(ones_q, 4'd9)     : wrap_down(ones_q, 4'd9);
        2'd1:    tens_d     = inc_ev ? wrap_up(tens_q, 4'd9)     : wrap_down(tens_q, 4'd9);
        2'd2:    hundreds_d = inc_ev ? wrap_up(hundreds_q, 4'd2) : wrap_down(hundreds_q, 4'd2);
        default: ;
      endcase
    end
  end

  // Binary value of the entered digits; only values up to 255 are transmittable
  always_comb begin
    value_sum = {5'd0, hundreds_q} * 9'd100 + {5'd0, tens_q} * 9'd10 + {5'd0, ones_q};
    value_ok  = (value_sum <= 9'd255);
    tx_byte   = value_ok ? value_sum[7:0] : 8'h00;
  end

  // TX handshake FSM: latch byte on accepted send, pulse start, then follow tx_busy high then low
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (send_ev && value_ok && !tx_busy) begin
          tx_data_d = tx_byte;
          state_d   = ST_START;
        end
      end
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Editing and TX state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 4'd0;
      cursor_q   <= 2'd0;
      tx_data_q  <= 8'h00;
      state_q    <= ST_IDLE;
    end else begin
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
      cursor_q   <= cursor_d;
      tx_data_q  <= tx_data_d;
      state_q    <= state_d;
    end
  end

  assign tx_start = (state_q == ST_START);
  assign tx_data  = tx_data_q;
  assign hundreds = hundreds_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign cursor   = cursor_q;

endmodule

// File: tb/tb_dec_byte_entry.sv
// tb_dec_byte_entry: randomized and directed bench for dec_byte_entry.
// A digit-level reference model (modular arithmetic on three decimal digits) predicts the outputs.
// Honours DEC_ENTRY_AUTO_REPEAT_EN for the held-button scenario.
module tb_dec_byte_entry;

  localparam int DB = 4;
  localparam int RP = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inc, btn_dec, btn_next, btn_send, tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [3:0] hundreds, tens, ones;
  logic [1:0] cursor;
  logic       value_ok;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  logic [7:0] start_data = 8'h00;

  // Reference model state
  int m_d[3];
  int m_cur;
  bit m_idle;
  int exp_starts;

  dec_byte_entry #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk(clk), .rst(rst),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next), .btn_send(btn_send),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .hundreds(hundreds), .tens(tens), .ones(ones), .cursor(cursor), .value_ok(value_ok)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Count start pulses (one count per high cycle) and capture the byte presented with them
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      start_cnt++;
      start_data = tx_data;
    end
  end

  // Global time limit so the run always ends
  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int m_value();
    return m_d[2] * 100 + m_d[1] * 10 + m_d[0];
  endfunction

  task automatic model_clear();
    m_d[0] = 0; m_d[1] = 0; m_d[2] = 0;
    m_cur = 0;
    m_idle = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {btn_send, btn_next, btn_dec, btn_inc} = 4'b0000;
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  // mask bits: 0=inc 1=dec 2=next 3=send; model applies send > next > inc/dec
  task automatic press(input logic [3:0] mask);
    int md;
    if (mask[3]) begin
      if (m_idle && m_value() <= 255 && !tx_busy) begin
        exp_starts++;
        m_idle = 1'b0;
      end
    end else if (mask[2]) begin
      m_cur = (m_cur + 1) % 3;
    end else if (mask[0] ^ mask[1]) begin
      md = (m_cur == 2) ? 3 : 10;
      if (mask[0]) m_d[m_cur] = (m_d[m_cur] + 1) % md;
      else         m_d[m_cur] = (m_d[m_cur] + md - 1) % md;
    end
    @(negedge clk);
    {btn_send, btn_next, btn_dec, btn_inc} = mask;
    repeat (12) @(negedge clk);
    {btn_send, btn_next, btn_dec, btn_inc} = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  task automatic finish_frame();
    repeat (3) @(negedge clk);
    tx_busy = 1'b1;
    repeat (10) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    m_idle = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_busy = 1'b0;
    {btn_send, btn_next, btn_dec, btn_inc} = 4'b1111;
    #1;
    n_checks++;
    if ({hundreds, tens, ones, cursor} !== 14'd0) begin
      n_fail++; $display("[TB] FAIL reset_digits: got %h expected 0", {hundreds, tens, ones, cursor});
    end
    n_checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("[TB] FAIL reset_tx: got start=%b data=%h expected 0/00", tx_start, tx_data);
    end
    n_checks++;
    if (value_ok !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_value_ok: got %b expected 1", value_ok);
    end
    repeat (4) @(negedge clk);
    {btn_send, btn_next, btn_dec, btn_inc} = 4'b0000;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_starts = start_cnt;
    repeat (20) @(negedge clk);
    n_checks++;
    if ({hundreds, tens, ones, cursor} !== 14'd0 || start_cnt != exp_starts) begin
      n_fail++; $display("[TB] FAIL reset_release: got %h starts=%0d expected 0 starts=%0d",
                         {hundreds, tens, ones, cursor}, start_cnt, exp_starts);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_inc = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    n_checks++;
    if (ones !== 4'd0) begin
      n_fail++; $display("[TB] FAIL bounce_filtered: got %0d expected 0", ones);
    end
    btn_inc = 1'b1;
    repeat (12) @(negedge clk);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    m_d[0] = 1;
    n_checks++;
    if ({hundreds, tens, ones, cursor} !== {4'd0, 4'd0, 4'd1, 2'd0}) begin
      n_fail++; $display("[TB] FAIL bounce_once: got h=%0d t=%0d o=%0d c=%0d expected 0/0/1/0",
                         hundreds, tens, ones, cursor);
    end
  endtask

  task automatic test_edit_sequence();
    do_reset();
    press(4'b0100);
    repeat (3) press(4'b0001);
    press(4'b0100);
    repeat (2) press(4'b0001);
    press(4'b0100);
    n_checks++;
    if ({hundreds, tens, ones, cursor} !== {4'd2, 4'd3, 4'd0, 2'd0}) begin
      n_fail++; $display("[TB] FAIL edit_seq: got h=%0d t=%0d o=%0d c=%0d expected 2/3/0/0",
                         hundreds, tens, ones, cursor);
    end
    press(4'b0010);
    n_checks++;
    if ({hundreds, tens, ones} !== {4'd2, 4'd3, 4'd9} || value_ok !== 1'b1) begin
      n_fail++; $display("[TB] FAIL edit_dec_wrap: got %0d%0d%0d ok=%b expected 239 ok=1",
                         hundreds, tens, ones, value_ok);
    end
  endtask

  task automatic test_send();
    do_reset();
    repeat (5) press(4'b0010);
    press(4'b0100);
    repeat (5) press(4'b0010);
    press(4'b0100);
    press(4'b0010);
    press(4'b0100);
    exp_starts = start_cnt;
    press(4'b1000);
    n_checks++;
    if (start_cnt != exp_starts || start_data !== 8'hFF) begin
      n_fail++; $display("[TB] FAIL send_255: got starts=%0d data=%h expected starts=%0d data=ff",
                         start_cnt, start_data, exp_starts);
    end
    repeat (3) @(negedge clk);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    press(4'b1000);
    n_checks++;
    if (start_cnt != exp_starts) begin
      n_fail++; $display("[TB] FAIL send_ignored_busy: got %0d expected %0d", start_cnt, exp_starts);
    end
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    m_idle = 1'b1;
    n_checks++;
    if (tx_data !== 8'hFF) begin
      n_fail++; $display("[TB] FAIL tx_data_hold: got %h expected ff", tx_data);
    end
    press(4'b1000);
    n_checks++;
    if (start_cnt != exp_starts) begin
      n_fail++; $display("[TB] FAIL send_after_idle: got %0d expected %0d", start_cnt, exp_starts);
    end
    finish_frame();
  endtask

  task automatic test_reject();
    do_reset();
    press(4'b0100);
    repeat (6) press(4'b0001);
    press(4'b0100);
    press(4'b0010);
    press(4'b0100);
    exp_starts = start_cnt;
    n_checks++;
    if (value_ok !== 1'b0) begin
      n_fail++; $display("[TB] FAIL value_ok_260: got %b expected 0", value_ok);
    end
    press(4'b1000);
    n_checks++;
    if (start_cnt != exp_starts) begin
      n_fail++; $display("[TB] FAIL send_260: got %0d starts expected %0d", start_cnt, exp_starts);
    end
    press(4'b0100);
    press(4'b0010);
    tx_busy = 1'b1;
    press(4'b1000);
    n_checks++;
    if (start_cnt != exp_starts || value_ok !== 1'b1) begin
      n_fail++; $display("[TB] FAIL send_while_busy: got starts=%0d ok=%b expected %0d ok=1",
                         start_cnt, value_ok, exp_starts);
    end
    tx_busy = 1'b0;
    press(4'b1000);
    n_checks++;
    if (start_cnt != exp_starts || start_data !== 8'hFA) begin
      n_fail++; $display("[TB] FAIL send_250: got starts=%0d data=%h expected %0d data=fa",
                         start_cnt, start_data, exp_starts);
    end
    finish_frame();
  endtask

  task automatic test_simultaneous();
    bit seen;
    do_reset();
    exp_starts = start_cnt;
    repeat (2) press(4'b0001);
    press(4'b0011);
    n_checks++;
    if (ones !== 4'd2) begin
      n_fail++; $display("[TB] FAIL inc_dec_cancel: got %0d expected 2", ones);
    end
    press(4'b1100);
    n_checks++;
    if (start_cnt != exp_starts || cursor !== 2'd0 || start_data !== 8'd2) begin
      n_fail++; $display("[TB] FAIL send_next: got starts=%0d cur=%0d data=%0d expected %0d/0/2",
                         start_cnt, cursor, start_data, exp_starts);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({hundreds, tens, ones, cursor} !== 14'd0 || tx_start !== 1'b0 ||
        tx_data !== 8'h00 || value_ok !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rst_wait_busy: got %h start=%b data=%h ok=%b expected 0/0/00/1",
                         {hundreds, tens, ones, cursor}, tx_start, tx_data, value_ok);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    press(4'b1000);
    n_checks++;
    if (start_cnt != exp_starts || start_data !== 8'h00) begin
      n_fail++; $display("[TB] FAIL idle_after_rst: got starts=%0d data=%h expected %0d data=00",
                         start_cnt, start_data, exp_starts);
    end
    finish_frame();
    press(4'b0001);
    @(negedge clk);
    btn_send = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1'b1;
    end
    exp_starts++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (!seen || tx_start !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_during_start: got seen=%b start=%b expected seen=1 start=0",
                         seen, tx_start);
    end
    btn_send = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_auto_repeat();
    int exp_ones;
`ifdef DEC_ENTRY_AUTO_REPEAT_EN
    exp_ones = 4;
`else
    exp_ones = 1;
`endif
    do_reset();
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (6 + 70) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    m_d[0] = exp_ones;
    n_checks++;
    if (ones !== 4'(exp_ones)) begin
      n_fail++; $display("[TB] FAIL auto_repeat: got %0d expected %0d", ones, exp_ones);
    end
  endtask

  task automatic test_random_edit();
    logic [3:0] masks [6];
    int r;
    masks[0] = 4'b0001; masks[1] = 4'b0001; masks[2] = 4'b0010;
    masks[3] = 4'b0100; masks[4] = 4'b0011; masks[5] = 4'b0101;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 5));
      press(masks[r]);
      n_checks++;
      if ({hundreds, tens, ones, cursor} !== {4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0]), 2'(m_cur)}) begin
        n_fail++; $display("[TB] FAIL rand_digits[%0d]: got h=%0d t=%0d o=%0d c=%0d expected %0d/%0d/%0d/%0d",
                           k, hundreds, tens, ones, cursor, m_d[2], m_d[1], m_d[0], m_cur);
      end
      n_checks++;
      if (value_ok !== (m_value() <= 255)) begin
        n_fail++; $display("[TB] FAIL rand_value_ok[%0d]: got %b expected value %0d <= 255",
                           k, value_ok, m_value());
      end
    end
  endtask

  // Run all scenarios in sequence and report
  initial begin
    exp_starts = 0;
    model_clear();
    test_reset();
    test_debounce();
    test_edit_sequence();
    test_send();
    test_reject();
    test_simultaneous();
    test_auto_repeat();
    test_random_edit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
